// File: rtl/jtkiwi_colmix_prio.sv
// Priority colour mixer: picks the winning layer index, fetches its 16-bit colour
// from a byte-wide palette RAM in three clocks and presents blank-aligned 5:5:5 RGB.
module jtkiwi_colmix_prio #(
    parameter int LAYERS = 3,
    parameter int PXLW   = 9,
    parameter int TRW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pxl_cen,
    input  logic                     LHBL,
    input  logic                     LVBL,
    input  logic [LAYERS-1:0]        layer_en,
    input  logic                     prio_rev,
    input  logic [LAYERS*PXLW-1:0]   pxl_in,
    input  logic [PXLW:0]            cpu_addr,
    input  logic [7:0]               cpu_dout,
    input  logic                     cpu_we,
    output logic [7:0]               cpu_din,
    output logic [4:0]               red,
    output logic [4:0]               green,
    output logic [4:0]               blue,
    output logic                     LHBL_dly,
    output logic                     LVBL_dly,
    output logic                     fetch_ovr
);

    localparam int AW    = PXLW + 1;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, LO, HI, CAP} state_t;

    state_t            state_q, state_d;
    logic [PXLW-1:0]   coll_q, coll_d;
    logic [7:0]        lo_byte_q, lo_byte_d;
    logic [14:0]       pending_q, pending_d;
    logic [14:0]       rgb_q, rgb_d;
    logic              lhbl_p_q, lhbl_p_d, lvbl_p_q, lvbl_p_d;
    logic              lhbl_dly_q, lhbl_dly_d, lvbl_dly_q, lvbl_dly_d;
    logic              fetch_ovr_q, fetch_ovr_d;

    // Layers re-ordered so that slot 0 is the lowest priority and slot LAYERS-1 the highest
    logic [PXLW-1:0]   ord_pxl    [LAYERS];
    logic              ord_en     [LAYERS];
    logic              ord_opaque [LAYERS];
    logic [PXLW-1:0]   chain      [LAYERS];
    logic [PXLW-1:0]   backdrop;
    logic [PXLW-1:0]   sel_idx;

    generate
        for (genvar gi = 0; gi < LAYERS; gi++) begin : g_order
            assign ord_pxl[gi]    = prio_rev ? pxl_in[gi*PXLW +: PXLW]
                                             : pxl_in[(LAYERS-1-gi)*PXLW +: PXLW];
            assign ord_en[gi]     = prio_rev ? layer_en[gi] : layer_en[LAYERS-1-gi];
            assign ord_opaque[gi] = ord_en[gi] && (ord_pxl[gi][TRW-1:0] != '0);
            if (gi == 0) begin : g_first
                assign chain[gi] = ord_opaque[gi] ? ord_pxl[gi] : backdrop;
            end else begin : g_next
                assign chain[gi] = ord_opaque[gi] ? ord_pxl[gi] : chain[gi-1];
            end
        end
    endgenerate

    assign backdrop = ord_en[0] ? ord_pxl[0] : '0;
    assign sel_idx  = chain[LAYERS-1];

    // Palette: fetch port reads, CPU port reads and writes; both reads see pre-write data
    logic [7:0]        mem [DEPTH];
    logic [7:0]        ram_q;
    logic [7:0]        cpu_rd_q;
    logic [AW-1:0]     fetch_addr;
    logic              unused_hi_msb;

    assign fetch_addr    = {coll_q, state_q == HI};
    assign unused_hi_msb = ram_q[7];

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[cpu_addr] <= cpu_dout;
        end
        ram_q <= mem[fetch_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rd_q <= '0;
        end else begin
            cpu_rd_q <= mem[cpu_addr];
        end
    end

    always_comb begin
        state_d     = state_q;
        coll_d      = coll_q;
        lo_byte_d   = lo_byte_q;
        pending_d   = pending_q;
        rgb_d       = rgb_q;
        lhbl_p_d    = lhbl_p_q;
        lvbl_p_d    = lvbl_p_q;
        lhbl_dly_d  = lhbl_dly_q;
        lvbl_dly_d  = lvbl_dly_q;
        fetch_ovr_d = fetch_ovr_q;

        case (state_q)
            LO:  state_d = HI;
            HI: begin
                lo_byte_d = ram_q;
                state_d   = CAP;
            end
            CAP: begin
                pending_d = {ram_q[6:0], lo_byte_q};
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pxl_cen) begin
            coll_d     = sel_idx;
            rgb_d      = (lhbl_p_q && lvbl_p_q) ? pending_q : '0;
            lhbl_dly_d = lhbl_p_q;
            lvbl_dly_d = lvbl_p_q;
            lhbl_p_d   = LHBL;
            lvbl_p_d   = LVBL;
            // A fetch cut short leaves pending untouched; the new one restarts from LO
            if (state_q == LO || state_q == HI) begin
                fetch_ovr_d = 1'b1;
            end
            state_d = LO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            coll_q      <= '0;
            lo_byte_q   <= '0;
            pending_q   <= '0;
            rgb_q       <= '0;
            lhbl_p_q    <= 1'b0;
            lvbl_p_q    <= 1'b0;
            lhbl_dly_q  <= 1'b0;
            lvbl_dly_q  <= 1'b0;
            fetch_ovr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coll_q      <= coll_d;
            lo_byte_q   <= lo_byte_d;
            pending_q   <= pending_d;
            rgb_q       <= rgb_d;
            lhbl_p_q    <= lhbl_p_d;
            lvbl_p_q    <= lvbl_p_d;
            lhbl_dly_q  <= lhbl_dly_d;
            lvbl_dly_q  <= lvbl_dly_d;
            fetch_ovr_q <= fetch_ovr_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign LHBL_dly  = lhbl_dly_q;
    assign LVBL_dly  = lvbl_dly_q;
    assign fetch_ovr = fetch_ovr_q;
    assign cpu_din   = cpu_rd_q;

endmodule

// File: tb/tb_jtkiwi_colmix_prio.sv
// Bench for jtkiwi_colmix_prio: directed and random pixels checked against a
// priority/palette/blanking model kept in the bench.
module tb_jtkiwi_colmix_prio;

    localparam int LAYERS = 3;
    localparam int PXLW   = 9;
    localparam int TRW    = 4;
    localparam int NBYTES = 1 << (PXLW + 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   pxl_cen;
    logic                   LHBL, LVBL;
    logic [LAYERS-1:0]      layer_en;
    logic                   prio_rev;
    logic [LAYERS*PXLW-1:0] pxl_in;
    logic [PXLW:0]          cpu_addr;
    logic [7:0]             cpu_dout;
    logic                   cpu_we;
    logic [7:0]             cpu_din;
    logic [4:0]             red, green, blue;
    logic                   LHBL_dly, LVBL_dly, fetch_ovr;

    jtkiwi_colmix_prio #(.LAYERS(LAYERS), .PXLW(PXLW), .TRW(TRW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .layer_en (layer_en),
        .prio_rev (prio_rev),
        .pxl_in   (pxl_in),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .cpu_din  (cpu_din),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly),
        .fetch_ovr(fetch_ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [7:0]  pal_b [NBYTES];
    logic [14:0] pend_m    = '0;
    logic        prev_lhbl = 1'b0;
    logic        prev_lvbl = 1'b0;
    logic        ovr_m     = 1'b0;
    int          last_gap  = 4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] pal_word(input int idx);
        return {pal_b[2*idx+1], pal_b[2*idx]};
    endfunction

    // Winner from the rules: walk layers highest priority first, backdrop is the last one
    function automatic int model_sel();
        int order[$];
        int result;
        bit found;
        logic [PXLW-1:0] p;
        found  = 1'b0;
        result = 0;
        for (int k = 0; k < LAYERS; k++) order.push_back(prio_rev ? LAYERS-1-k : k);
        for (int i = 0; i < LAYERS; i++) begin
            p = pxl_in[order[i]*PXLW +: PXLW];
            if (!found && layer_en[order[i]] && p[TRW-1:0] != 0) begin
                result = int'(p);
                found  = 1'b1;
            end
        end
        if (!found && layer_en[order[LAYERS-1]])
            result = int'(pxl_in[order[LAYERS-1]*PXLW +: PXLW]);
        return result;
    endfunction

    task automatic set_layers(input logic [PXLW-1:0] l0, input logic [PXLW-1:0] l1,
                              input logic [PXLW-1:0] l2);
        pxl_in = {l2, l1, l0};
    endtask

    task automatic rand_inputs(input bit blank_ok);
        logic [PXLW-1:0] p;
        for (int k = 0; k < LAYERS; k++) begin
            p = PXLW'($urandom);
            if ($urandom_range(0, 2) == 0) p[TRW-1:0] = '0;
            pxl_in[k*PXLW +: PXLW] = p;
        end
        layer_en = LAYERS'($urandom);
        prio_rev = 1'($urandom);
        LHBL = blank_ok ? ($urandom_range(0, 4) != 0) : 1'b1;
        LVBL = blank_ok ? ($urandom_range(0, 7) != 0) : 1'b1;
    endtask

    task automatic cpu_write(input int a, input logic [7:0] d);
        cpu_addr = (PXLW+1)'(a);
        cpu_dout = d;
        cpu_we   = 1'b1;
        @(posedge clk); #1;
        cpu_we   = 1'b0;
        pal_b[a] = d;
    endtask

    task automatic cpu_read(input int a);
        cpu_addr = (PXLW+1)'(a);
        @(posedge clk); #1;
        chk("cpu_din", 32'(cpu_din), 32'(pal_b[a]));
    endtask

    // One pixel: pxl_cen pulse, check the outputs for the previous pixel, wait gap clocks.
    // With tear set, the low byte of the entry being fetched is written in the LO cycle.
    task automatic pixel(input int gap, input bit tear, input logic [7:0] tear_data);
        int idx;
        logic [15:0] word;
        logic [14:0] exp_rgb;
        idx     = model_sel();
        ovr_m   = ovr_m | (last_gap < 3);
        exp_rgb = (prev_lhbl && prev_lvbl) ? pend_m : 15'd0;
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        chk("lhbl_dly", 32'(LHBL_dly), 32'(prev_lhbl));
        chk("lvbl_dly", 32'(LVBL_dly), 32'(prev_lvbl));
        chk("fetch_ovr", 32'(fetch_ovr), 32'(ovr_m));
        prev_lhbl = LHBL;
        prev_lvbl = LVBL;
        word = pal_word(idx);
        if (tear) begin
            cpu_addr = (PXLW+1)'(2*idx);
            cpu_dout = tear_data;
            cpu_we   = 1'b1;
        end
        repeat (gap - 1) begin
            @(posedge clk); #1;
            if (cpu_we) begin
                pal_b[cpu_addr] = cpu_dout;
                cpu_we = 1'b0;
            end
        end
        if (gap >= 4) pend_m = word[14:0];
        last_gap = gap;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old_lo;
        rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        layer_en = '1; prio_rev = 1'b0; pxl_in = '0;
        cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_lhbl_dly", 32'(LHBL_dly), 32'd0);
        chk("rst_lvbl_dly", 32'(LVBL_dly), 32'd0);
        chk("rst_ovr", 32'(fetch_ovr), 32'd0);
        chk("rst_cpu_din", 32'(cpu_din), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill palette, then plant the directed colours
        for (int a = 0; a < NBYTES; a++) cpu_write(a, 8'($urandom));
        cpu_write(2*'h012, 8'h00); cpu_write(2*'h012+1, 8'h7C);
        cpu_write(2*'h034, 8'h1F); cpu_write(2*'h034+1, 8'h00);

        // CPU port readback
        cpu_write('h3FF, 8'hA5);
        cpu_addr = 10'h3FF;
        @(posedge clk); #1;
        chk("cpu_a5", 32'(cpu_din), 32'hA5);
        for (int i = 0; i < 6; i++) cpu_read($urandom_range(0, NBYTES-1));

        // Priority
        LHBL = 1'b1; LVBL = 1'b1; layer_en = 3'b111;
        set_layers(9'h012, 9'h034, 9'h000); prio_rev = 1'b0;
        pixel(4, 1'b0, 8'h00);
        prio_rev = 1'b1;
        pixel(4, 1'b0, 8'h00);
        chk("prio_red", 32'(red), 32'd31);
        chk("prio_green", 32'(green), 32'd0);
        chk("prio_blue", 32'(blue), 32'd0);
        set_layers(9'h010, 9'h034, 9'h000); prio_rev = 1'b0;
        pixel(4, 1'b0, 8'h00);
        chk("rev_blue", 32'(blue), 32'd31);
        chk("rev_red", 32'(red), 32'd0);

        // Enable / backdrop
        set_layers(9'h010, 9'h020, 9'h030); layer_en = 3'b011;
        pixel(4, 1'b0, 8'h00);
        chk("transp_blue", 32'(blue), 32'd31);
        set_layers(9'h010, 9'h020, 9'h120); layer_en = 3'b111;
        pixel(4, 1'b0, 8'h00);
        chk("backdrop_idx0", 32'({red, green, blue}), 32'(pal_word(0) & 16'h7FFF));
        pixel(4, 1'b0, 8'h00);
        chk("backdrop_120", 32'({red, green, blue}), 32'(pal_word('h120) & 16'h7FFF));

        // Blanking: LHBL low for pixels 2..6
        for (int i = 0; i < 10; i++) begin
            rand_inputs(1'b0);
            LHBL = !(i >= 2 && i <= 6);
            pixel(4, 1'b0, 8'h00);
        end
        LHBL = 1'b1;

        // Tear: write the low byte of the entry being fetched during LO
        set_layers(9'h055, 9'h000, 9'h000); layer_en = 3'b111; prio_rev = 1'b0;
        old_lo = pal_b[2*'h055];
        pixel(4, 1'b1, ~old_lo);
        pixel(4, 1'b0, 8'h00);
        chk("tear_old_blue", 32'(blue), 32'(old_lo[4:0]));
        pixel(4, 1'b0, 8'h00);
        chk("tear_new_blue", 32'(blue), 32'(5'(~old_lo)));

        // Random pixels with CPU traffic between fetches
        for (int i = 0; i < 40; i++) begin
            rand_inputs(1'b1);
            pixel($urandom_range(4, 6), 1'b0, 8'h00);
            if ($urandom_range(0, 3) == 0) cpu_write($urandom_range(0, NBYTES-1), 8'($urandom));
            if ($urandom_range(0, 3) == 0) cpu_read($urandom_range(0, NBYTES-1));
        end

        // Overrun
        for (int i = 0; i < 6; i++) begin
            rand_inputs(1'b0);
            pixel((i < 2) ? 2 : 4, 1'b0, 8'h00);
        end
        chk("ovr_sticky", 32'(fetch_ovr), 32'd1);

        // Asynchronous reset in the middle of a fetch
        rand_inputs(1'b0);
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rgb", 32'({red, green, blue}), 32'd0);
        chk("midrst_lhbl_dly", 32'(LHBL_dly), 32'd0);
        chk("midrst_lvbl_dly", 32'(LVBL_dly), 32'd0);
        chk("midrst_ovr", 32'(fetch_ovr), 32'd0);
        chk("midrst_cpu_din", 32'(cpu_din), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pend_m = '0; prev_lhbl = 1'b0; prev_lvbl = 1'b0; ovr_m = 1'b0; last_gap = 4;
        rand_inputs(1'b0);
        pixel(4, 1'b0, 8'h00);
        chk("postrst_rgb", 32'({red, green, blue}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rand_inputs(1'b0);
            pixel(4, 1'b0, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
